ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed driver for two 4-digit seven-segment banks.
// A prescaler steps a shared digit select; a staged word is moved into the
// displayed register only at frame boundaries, so a frame is never torn.
// Optional feature macro: SSD_ZERO_BLANK_EN (blank leading zero digits).
`timescale 1ns/1ps

module ssd_scan_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic        load_ready,
  output logic        frame_done,
  output logic [6:0]  D0_SEG,
  output logic [6:0]  D1_SEG,
  output logic [3:0]  D0_AN,
  output logic [3:0]  D1_AN
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       sel_q, sel_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      staging_q, staging_d;
  logic             pending_q, pending_d;

  logic             tick;
  logic             frame_tick;
  logic             load_accept;
  logic [3:0]       nib_d0;
  logic [3:0]       nib_d1;
  logic [3:0]       an;

  // Active-low hex glyphs, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign tick        = (count_q == CNT_MAX);
  assign frame_tick  = tick && (sel_q == 2'd3);
  assign load_ready  = !pending_q;
  assign load_accept = load && !pending_q;
  assign frame_done  = frame_tick && !RST;

  // Next-state: prescaler, digit select, and the staging/display handoff.
  // A boundary transfer only happens with pending already set, and a new load
  // is only accepted with pending clear, so the two never collide; a load on a
  // boundary cycle with pending clear therefore waits for the next boundary.
  always_comb begin
    count_d   = tick ? '0 : (count_q + CNT_ONE);
    sel_d     = tick ? (sel_q + 2'd1) : sel_q;
    disp_d    = disp_q;
    staging_d = staging_q;
    pending_d = pending_q;
    if (frame_tick && pending_q) begin
      disp_d    = staging_q;
      pending_d = 1'b0;
    end
    if (load_accept) begin
      staging_d = data_in;
      pending_d = 1'b1;
    end
  end

  // State registers; reset wins over both tick and load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q   <= '0;
      sel_q     <= 2'd0;
      disp_q    <= 32'd0;
      staging_q <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      sel_q     <= sel_d;
      disp_q    <= disp_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
    end
  end

  // Pick the nibble for the current digit; sel 0 is the most significant.
  always_comb begin
    nib_d0 = 4'h0;
    nib_d1 = 4'h0;
    case (sel_q)
      2'd0: begin nib_d0 = disp_q[31:28]; nib_d1 = disp_q[15:12]; end
      2'd1: begin nib_d0 = disp_q[27:24]; nib_d1 = disp_q[11:8];  end
      2'd2: begin nib_d0 = disp_q[23:20]; nib_d1 = disp_q[7:4];   end
      default: begin nib_d0 = disp_q[19:16]; nib_d1 = disp_q[3:0]; end
    endcase
  end

  // One-cold anode select shared by both banks.
  always_comb begin
    an        = 4'b1111;
    an[sel_q] = 1'b0;
  end

  assign D0_AN = an;
  assign D1_AN = an;

`ifdef SSD_ZERO_BLANK_EN
  logic blank_d0;
  logic blank_d1;

  // A digit is blanked when it and every more significant digit of its bank
  // are zero; the last digit is always lit so an all-zero bank shows "0".
  always_comb begin
    blank_d0 = 1'b0;
    blank_d1 = 1'b0;
    case (sel_q)
      2'd0: begin blank_d0 = (disp_q[31:28] == 4'h0);  blank_d1 = (disp_q[15:12] == 4'h0);  end
      2'd1: begin blank_d0 = (disp_q[31:24] == 8'h00); blank_d1 = (disp_q[15:8] == 8'h00);  end
      2'd2: begin blank_d0 = (disp_q[31:20] == 12'h000); blank_d1 = (disp_q[15:4] == 12'h000); end
      default: begin blank_d0 = 1'b0; blank_d1 = 1'b0; end
    endcase
  end

  // Segment drive with leading-zero suppression.
  always_comb begin
    D0_SEG = blank_d0 ? 7'b1111111 : hex_to_seg(nib_d0);
    D1_SEG = blank_d1 ? 7'b1111111 : hex_to_seg(nib_d1);
  end
`else
  // Segment drive straight from the registered nibble.
  always_comb begin
    D0_SEG = hex_to_seg(nib_d0);
    D1_SEG = hex_to_seg(nib_d1);
  end
`endif

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed checks of scan timing, load handshake,
// frame-boundary handoff, reset and (when SSD_ZERO_BLANK_EN is set) blanking.
`timescale 1ns/1ps

module tb_ssd_scan_ctrl;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_F = 7'b0001110;
`ifdef SSD_ZERO_BLANK_EN
  localparam logic [6:0] ZLEAD = 7'b1111111;
`else
  localparam logic [6:0] ZLEAD = SEG_0;
`endif

  logic        CLK;
  logic        RST;
  logic [31:0] data_in;
  logic        load;
  logic        load_ready;
  logic        frame_done;
  logic [6:0]  D0_SEG;
  logic [6:0]  D1_SEG;
  logic [3:0]  D0_AN;
  logic [3:0]  D1_AN;

  int total;
  int bad;
  int k;

  ssd_scan_ctrl #(.TICK_DIV(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .data_in    (data_in),
    .load       (load),
    .load_ready (load_ready),
    .frame_done (frame_done),
    .D0_SEG     (D0_SEG),
    .D1_SEG     (D1_SEG),
    .D0_AN      (D0_AN),
    .D1_AN      (D1_AN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rst, input logic ld, input logic [31:0] data);
    RST     = rst;
    load    = ld;
    data_in = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // k counts rising edges since reset was released.
  task automatic advance();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic advanceTo(input int target);
    while (k < target) advance();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;

    // Reset held for two edges.
    applyStimulus(1'b1, 1'b0, 32'h0);
    advance();
    advance();
    k = 0;
    checkOutput("rst_an0", 32'(D0_AN), 32'(4'b1110));
    checkOutput("rst_an1", 32'(D1_AN), 32'(4'b1110));
    checkOutput("rst_ready", 32'(load_ready), 32'd1);
    checkOutput("rst_fdone", 32'(frame_done), 32'd0);
    checkOutput("rst_seg0", 32'(D0_SEG), 32'(ZLEAD));
    checkOutput("rst_seg1", 32'(D1_SEG), 32'(ZLEAD));
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Free-running scan: digit steps every 4 cycles, frame_done on cycle 15.
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_an;
      advance();
      exp_an = ~(4'b0001 << ((i / 4) % 4));
      checkOutput($sformatf("scan_an_k%0d", i), 32'(D0_AN), 32'(exp_an));
      checkOutput($sformatf("scan_fd_k%0d", i), 32'(frame_done), (i == 15) ? 32'd1 : 32'd0);
    end
    checkOutput("scan_an1_k16", 32'(D1_AN), 32'(4'b1110));

    // Mid-frame load, followed by a second load that must be ignored.
    checkOutput("ld_ready_pre", 32'(load_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h12AB_F008);
    advance();
    checkOutput("ld_ready_busy", 32'(load_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
    advance();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("ld_ready_busy2", 32'(load_ready), 32'd0);
    checkOutput("ld_midframe_d0", 32'(D0_SEG), 32'(ZLEAD));
    advanceTo(31);
    checkOutput("ld_bound_fd", 32'(frame_done), 32'd1);
    checkOutput("ld_bound_old", 32'(D0_SEG), 32'(SEG_0));
    advance();
    checkOutput("ld_ready_free", 32'(load_ready), 32'd1);
    checkOutput("ld_d0_s0", 32'(D0_SEG), 32'(SEG_1));
    checkOutput("ld_d1_s0", 32'(D1_SEG), 32'(SEG_F));
    advanceTo(36);
    checkOutput("ld_d0_s1", 32'(D0_SEG), 32'(SEG_2));
    checkOutput("ld_d1_s1", 32'(D1_SEG), 32'(SEG_0));
    advanceTo(40);
    checkOutput("ld_an_s2", 32'(D1_AN), 32'(4'b1011));
    checkOutput("ld_d0_s2", 32'(D0_SEG), 32'(SEG_A));
    checkOutput("ld_d1_s2", 32'(D1_SEG), 32'(SEG_0));
    advanceTo(44);
    checkOutput("ld_d0_s3", 32'(D0_SEG), 32'(SEG_B));
    checkOutput("ld_d1_s3", 32'(D1_SEG), 32'(SEG_8));

    // Load accepted on the frame_done cycle lands one frame later.
    advanceTo(47);
    checkOutput("sim_fd", 32'(frame_done), 32'd1);
    checkOutput("sim_ready", 32'(load_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h3333_7777);
    advance();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("sim_busy", 32'(load_ready), 32'd0);
    checkOutput("sim_keep_d0", 32'(D0_SEG), 32'(SEG_1));
    checkOutput("sim_keep_d1", 32'(D1_SEG), 32'(SEG_F));
    advanceTo(63);
    checkOutput("sim_fd2", 32'(frame_done), 32'd1);
    checkOutput("sim_keep_d0_s3", 32'(D0_SEG), 32'(SEG_B));
    advance();
    checkOutput("sim_new_d0", 32'(D0_SEG), 32'(SEG_3));
    checkOutput("sim_new_d1", 32'(D1_SEG), 32'(SEG_7));
    checkOutput("sim_ready2", 32'(load_ready), 32'd1);

    // Leading-zero word.
    applyStimulus(1'b0, 1'b1, 32'h0000_0030);
    advance();
    applyStimulus(1'b0, 1'b0, 32'h0);
    advanceTo(80);
    checkOutput("bl_d0_s0", 32'(D0_SEG), 32'(ZLEAD));
    checkOutput("bl_d1_s0", 32'(D1_SEG), 32'(ZLEAD));
    advanceTo(84);
    checkOutput("bl_d0_s1", 32'(D0_SEG), 32'(ZLEAD));
    checkOutput("bl_d1_s1", 32'(D1_SEG), 32'(ZLEAD));
    advanceTo(88);
    checkOutput("bl_d0_s2", 32'(D0_SEG), 32'(ZLEAD));
    checkOutput("bl_d1_s2", 32'(D1_SEG), 32'(SEG_3));
    advanceTo(92);
    checkOutput("bl_d0_s3", 32'(D0_SEG), 32'(SEG_0));
    checkOutput("bl_d1_s3", 32'(D1_SEG), 32'(SEG_0));

    // Reset mid-frame drops a pending word.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    advance();
    checkOutput("mr_busy", 32'(load_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    advance();
    checkOutput("mr_an", 32'(D0_AN), 32'(4'b1110));
    checkOutput("mr_ready", 32'(load_ready), 32'd1);
    checkOutput("mr_fd", 32'(frame_done), 32'd0);
    k = 0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    advanceTo(15);
    checkOutput("mr_fd_bound", 32'(frame_done), 32'd1);
    advance();
    checkOutput("mr_after_d0", 32'(D0_SEG), 32'(ZLEAD));
    checkOutput("mr_after_d1", 32'(D1_SEG), 32'(ZLEAD));
    checkOutput("mr_after_an", 32'(D1_AN), 32'(4'b1110));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
